// File: rtl/imsic_setipnum_arbiter.sv
// rtl/imsic_setipnum_arbiter.sv - per-requester setipnum FIFOs with identity filter and round-robin file write arbiter
`timescale 1ns/1ps
module imsic_setipnum_arbiter #(
    parameter int NR_REQ        = 2,
    parameter int NR_SRC_LEN    = 32,
    parameter int NR_SRC        = 64,
    parameter int NR_INTP_FILES = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int FILE_W        = $clog2(NR_INTP_FILES)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NR_REQ-1:0]            i_req_valid,
    output logic [NR_REQ-1:0]            o_req_ready,
    input  logic [NR_REQ*NR_SRC_LEN-1:0] i_req_setipnum,
    input  logic [NR_REQ*FILE_W-1:0]     i_req_file,
    input  logic [NR_INTP_FILES-1:0]     i_file_busy,
    output logic [NR_SRC_LEN-1:0]        o_setipnum,
    output logic [NR_INTP_FILES-1:0]     o_setipnum_we,
    output logic [NR_REQ-1:0]            o_grant,
    output logic [15:0]                  o_drop_cnt,
    output logic [NR_REQ-1:0]            o_fifo_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REQ_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [NR_SRC_LEN-1:0] id_mem_q   [NR_REQ][FIFO_DEPTH];
    logic [FILE_W-1:0]     file_mem_q [NR_REQ][FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q   [NR_REQ];
    logic [PTR_W:0]        rd_ptr_q   [NR_REQ];
    logic [REQ_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic [NR_SRC_LEN-1:0] setipnum_q, setipnum_d;
    logic [NR_INTP_FILES-1:0] we_q, we_d;
    logic [NR_REQ-1:0]     grant_q, grant_d;

    logic [NR_SRC_LEN-1:0] req_id    [NR_REQ];
    logic [FILE_W-1:0]     req_file  [NR_REQ];
    logic [NR_SRC_LEN-1:0] head_id   [NR_REQ];
    logic [FILE_W-1:0]     head_file [NR_REQ];
    logic [NR_REQ-1:0]     full, empty, accept, good, push, drop, eligible, pop;
    logic                  gnt_found;
    logic [REQ_W-1:0]      gnt_idx;
    logic [16:0]           drop_sum, drop_ext;

    // Full/empty come from registered pointers only, so ready never sees a same-cycle pop.
    always_comb begin
        for (int r = 0; r < NR_REQ; r++) begin
            req_id[r]    = i_req_setipnum[r*NR_SRC_LEN +: NR_SRC_LEN];
            req_file[r]  = i_req_file[r*FILE_W +: FILE_W];
            empty[r]     = (wr_ptr_q[r] == rd_ptr_q[r]);
            full[r]      = (wr_ptr_q[r][PTR_W] != rd_ptr_q[r][PTR_W]) &&
                           (wr_ptr_q[r][PTR_W-1:0] == rd_ptr_q[r][PTR_W-1:0]);
            accept[r]    = i_req_valid[r] & ~full[r];
            good[r]      = (req_id[r] != '0) &&
                           (req_id[r] < NR_SRC_LEN'(NR_SRC)) &&
                           (32'(req_file[r]) < 32'(NR_INTP_FILES));
            push[r]      = accept[r] & good[r];
            drop[r]      = accept[r] & ~good[r];
            head_id[r]   = id_mem_q[r][rd_ptr_q[r][PTR_W-1:0]];
            head_file[r] = file_mem_q[r][rd_ptr_q[r][PTR_W-1:0]];
            eligible[r]  = ~empty[r] & ~i_file_busy[head_file[r]];
        end
    end

    always_comb begin
        int c;
        c         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            c = (int'(rr_ptr_q) + k) % NR_REQ;
            if (!gnt_found && eligible[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = REQ_W'(c);
            end
        end
    end

    always_comb begin
        pop        = '0;
        grant_d    = '0;
        we_d       = '0;
        setipnum_d = '0;
        rr_ptr_d   = rr_ptr_q;
        if (gnt_found) begin
            pop[gnt_idx]              = 1'b1;
            grant_d[gnt_idx]          = 1'b1;
            we_d[head_file[gnt_idx]]  = 1'b1;
            setipnum_d                = head_id[gnt_idx];
            rr_ptr_d                  = REQ_W'((int'(gnt_idx) + 1) % NR_REQ);
        end
    end

    // Simultaneous drops from several requesters are summed, then clamped.
    always_comb begin
        drop_sum = '0;
        for (int r = 0; r < NR_REQ; r++) begin
            drop_sum = drop_sum + 17'(drop[r]);
        end
        drop_ext   = {1'b0, drop_cnt_q} + drop_sum;
        drop_cnt_d = drop_ext[16] ? 16'hFFFF : drop_ext[15:0];
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < NR_REQ; r++) begin
            if (push[r]) begin
                id_mem_q[r][wr_ptr_q[r][PTR_W-1:0]]   <= req_id[r];
                file_mem_q[r][wr_ptr_q[r][PTR_W-1:0]] <= req_file[r];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NR_REQ; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
            end
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
            setipnum_q <= '0;
            we_q       <= '0;
            grant_q    <= '0;
        end else begin
            for (int r = 0; r < NR_REQ; r++) begin
                if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PTR_ONE;
                if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + PTR_ONE;
            end
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            setipnum_q <= setipnum_d;
            we_q       <= we_d;
            grant_q    <= grant_d;
        end
    end

    assign o_req_ready   = ~full;
    assign o_fifo_empty  = empty;
    assign o_setipnum    = setipnum_q;
    assign o_setipnum_we = we_q;
    assign o_grant       = grant_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_imsic_setipnum_arbiter.sv
// tb/tb_imsic_setipnum_arbiter.sv - scoreboard bench for imsic_setipnum_arbiter
`timescale 1ns/1ps
module tb_imsic_setipnum_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_setipnum = '0;
    logic [3:0]  req_file = '0;
    logic [2:0]  file_busy = '0;
    logic [31:0] setipnum;
    logic [2:0]  setipnum_we;
    logic [1:0]  grant;
    logic [15:0] drop_cnt;
    logic [1:0]  fifo_empty;

    imsic_setipnum_arbiter dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_setipnum (req_setipnum),
        .i_req_file     (req_file),
        .i_file_busy    (file_busy),
        .o_setipnum     (setipnum),
        .o_setipnum_we  (setipnum_we),
        .o_grant        (grant),
        .o_drop_cnt     (drop_cnt),
        .o_fifo_empty   (fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] id;
        logic [2:0]  we;
        logic [1:0]  gnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the oldest expected entry, including the cycle it is due in.
    always @(negedge clk) begin
        if (!rst && (setipnum_we != 0 || grant != 0 || setipnum != 0)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got id=%0d we=%b gnt=%b at cycle %0d, required no strobe",
                         setipnum, setipnum_we, grant, cyc);
            end else begin
                e = exp_q.pop_front();
                if (setipnum !== e.id || setipnum_we !== e.we || grant !== e.gnt || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL strobe: got id=%0d we=%b gnt=%b cyc=%0d, required id=%0d we=%b gnt=%b cyc=%0d",
                             setipnum, setipnum_we, grant, cyc, e.id, e.we, e.gnt, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [31:0] id, input logic [1:0] f);
        req_valid[r]           = v;
        req_setipnum[r*32 +: 32] = id;
        req_file[r*2 +: 2]     = f;
    endtask

    task automatic expect_strobe(input logic [31:0] id, input logic [2:0] we, input logic [1:0] gnt, input int c);
        exp_t x;
        x.id = id; x.we = we; x.gnt = gnt; x.cyc = c;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (6) tick();
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int c;
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        do_reset();
        chk("reset_empty", fifo_empty, 2'b11);
        chk("reset_ready", req_ready, 2'b11);
        chk("reset_id", setipnum, 0);
        chk("reset_we", setipnum_we, 0);
        chk("reset_grant", grant, 0);
        chk("reset_drop", drop_cnt, 0);

        // single write: strobe exactly two cycles after drive
        c = cyc;
        expect_strobe(5, 3'b010, 2'b01, c + 2);
        set_req(0, 1, 5, 1);
        tick();
        set_req(0, 0, 0, 0);
        repeat (4) tick();
        chk("single_drop", drop_cnt, 0);
        drain("drain_single");

        // round robin with both requesters streaming to file 0
        do_reset();
        c = cyc;
        expect_strobe(10, 3'b001, 2'b01, c + 2);
        expect_strobe(20, 3'b001, 2'b10, c + 3);
        expect_strobe(11, 3'b001, 2'b01, c + 4);
        expect_strobe(21, 3'b001, 2'b10, c + 5);
        expect_strobe(12, 3'b001, 2'b01, c + 6);
        expect_strobe(22, 3'b001, 2'b10, c + 7);
        set_req(0, 1, 10, 0); set_req(1, 1, 20, 0); tick();
        set_req(0, 1, 11, 0); set_req(1, 1, 21, 0); tick();
        set_req(0, 1, 12, 0); set_req(1, 1, 22, 0); tick();
        set_req(0, 0, 0, 0);  set_req(1, 0, 0, 0);
        drain("drain_rr");

        // backpressure: all files busy, fill FIFO 0 past capacity
        do_reset();
        file_busy = 3'b111;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1, 32'(i + 1), 0);
            chk($sformatf("ready_fill_%0d", i), req_ready[0], (i < 4) ? 1 : 0);
            tick();
        end
        set_req(0, 0, 0, 0);
        repeat (3) tick();
        chk("full_not_empty", fifo_empty[0], 0);
        chk("full_ready_low", req_ready[0], 0);
        c = cyc;
        for (int i = 0; i < 4; i++) expect_strobe(32'(i + 1), 3'b001, 2'b01, c + 1 + i);
        file_busy = 3'b000;
        tick();
        chk("ready_after_pop", req_ready[0], 1);
        drain("drain_full");

        // head-of-line: req0 waits on busy file 2, req1 flows to file 0
        do_reset();
        file_busy = 3'b100;
        c = cyc;
        expect_strobe(30, 3'b001, 2'b10, c + 2);
        expect_strobe(31, 3'b001, 2'b10, c + 3);
        expect_strobe(32, 3'b001, 2'b10, c + 4);
        set_req(0, 1, 7, 2); set_req(1, 1, 30, 0); tick();
        set_req(0, 0, 0, 0); set_req(1, 1, 31, 0); tick();
        set_req(1, 1, 32, 0); tick();
        set_req(1, 0, 0, 0);
        repeat (4) tick();
        chk("hol_stalled", fifo_empty, 2'b10);
        chk("hol_seen_req1", exp_q.size(), 0);
        c = cyc;
        expect_strobe(7, 3'b100, 2'b01, c + 1);
        file_busy = 3'b000;
        drain("drain_hol");

        // filtering and drop counter saturation
        do_reset();
        set_req(0, 1, 0, 0);  chk("ready_drop_id0", req_ready[0], 1);  tick();
        set_req(0, 1, 64, 0); chk("ready_drop_id64", req_ready[0], 1); tick();
        set_req(0, 1, 5, 3);  chk("ready_drop_f3", req_ready[0], 1);   tick();
        set_req(0, 0, 0, 0);
        tick();
        chk("drop_cnt_3", drop_cnt, 3);
        chk("drop_not_stored", fifo_empty, 2'b11);
        set_req(0, 1, 0, 0); set_req(1, 1, 0, 0);
        repeat (32765) tick();
        set_req(1, 0, 0, 0);
        tick();
        set_req(0, 0, 0, 0);
        chk("drop_cnt_fffe", drop_cnt, 16'hFFFE);
        set_req(0, 1, 0, 0); tick();
        set_req(0, 0, 0, 0);
        chk("drop_cnt_ffff", drop_cnt, 16'hFFFF);
        set_req(0, 1, 0, 0); set_req(1, 1, 0, 0); tick();
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
        chk("drop_cnt_sat", drop_cnt, 16'hFFFF);
        chk("drop_ready", req_ready, 2'b11);
        drain("drain_drop");

        // asynchronous reset while a strobe is showing and entries are queued
        do_reset();
        file_busy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1, 32'(i + 1), 0);
            tick();
        end
        set_req(0, 0, 0, 0);
        chk("arst_queued", fifo_empty[0], 0);
        c = cyc;
        expect_strobe(1, 3'b001, 2'b01, c + 1);
        file_busy = 3'b000;
        tick();
        #6;
        rst = 1'b1;
        #1;
        chk("arst_we", setipnum_we, 0);
        chk("arst_grant", grant, 0);
        chk("arst_id", setipnum, 0);
        chk("arst_empty", fifo_empty, 2'b11);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("arst_consumed", exp_q.size(), 0);
        drain("drain_arst");
        chk("arst_drop", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imsic_setipnum_arbiter.md
Name: imsic_setipnum_arbiter

Overview:
- Sequences set-interrupt-pending (setipnum) writes from several requesters into the IMSIC interrupt files. Typical requesters: the memory-mapped MSI write path, the APLIC MSI forwarder, and debug injection.
- Buffers each requester in a small FIFO and filters invalid identities.
- Grants one write per cycle by round-robin, skipping files that signal busy.
- Sits between the setipnum producers and the per-file pending-bit arrays.

Parameters:
- NR_REQ, 2, number of requesters.
- NR_SRC_LEN, 32, width of an identity word.
- NR_SRC, 64, number of identities implemented per file; valid range is 1..NR_SRC-1.
- NR_INTP_FILES, 3, interrupt files served (M, S, VS...).
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, at least 2.
- FILE_W, $clog2(NR_INTP_FILES), width of a file index (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NR_REQ  per-requester write valid.
- o_req_ready  out  NR_REQ  per-requester accept.
- i_req_setipnum  in  NR_REQ*NR_SRC_LEN  identity per requester; requester r uses slice r.
- i_req_file  in  NR_REQ*FILE_W  target file per requester.
- i_file_busy  in  NR_INTP_FILES  file cannot take a write this cycle.
- o_setipnum  out  NR_SRC_LEN  identity being written.
- o_setipnum_we  out  NR_INTP_FILES  one-hot write strobe, 1-cycle pulse.
- o_grant  out  NR_REQ  one-hot requester served by the current strobe.
- o_drop_cnt  out  16  saturating count of dropped invalid writes.
- o_fifo_empty  out  NR_REQ  per-FIFO empty flag.

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty (o_fifo_empty all 1); rr_ptr=0.
  - o_setipnum=0, o_setipnum_we=0, o_grant=0, o_drop_cnt=0.
  - Reset mid-operation discards all queued entries. No strobe is emitted during reset or in the first cycle after release.
- Handshake:
  - A write is accepted when i_req_valid[r] & o_req_ready[r].
  - o_req_ready[r] = !full[r]. It is registered-state based only; it never depends on a same-cycle pop.
  - Valid may be held across cycles; each accepted cycle is a separate write.
- Filter at accept:
  - A write is invalid if identity==0, identity>=NR_SRC, or file>=NR_INTP_FILES.
  - Invalid writes are accepted (ready still required), not stored, and increment o_drop_cnt, which saturates at 16'hFFFF.
  - Several requesters dropping in the same cycle add their count, saturating.
- FIFO:
  - Push and pop on the same FIFO in the same cycle keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: a pushed entry is poppable from the next cycle.
- Arbitration, each cycle:
  - Eligible(r) = !empty[r] & !i_file_busy[head_file[r]].
  - Grant the first eligible r searching rr_ptr, rr_ptr+1, ... mod NR_REQ.
  - On grant: pop that FIFO and set rr_ptr = (r+1) mod NR_REQ.
  - With no eligible requester, rr_ptr is held.
  - A busy file blocks only the FIFO whose head targets it. There is no reordering within a FIFO.
- Output, registered:
  - In the cycle after a grant: o_setipnum = head identity, o_setipnum_we = onehot(head_file), o_grant = onehot(r).
  - Otherwise all three are 0.
  - Latency from accept to strobe is at least 2 cycles: accept in N, pop in N+1, strobe in N+2.
  - Throughput is one strobe per cycle.
- Duplicate identities pass through unchanged; setting pending is idempotent in the file.
- i_file_busy is sampled only in the pop cycle; the strobe is never retracted.

Test Plan:
- Single write: req0 sends id=5, file=1 at cycle 1 → o_setipnum=5, o_setipnum_we=3'b010, o_grant=2'b01 at cycle 3 only; o_drop_cnt=0.
- Round-robin fairness: both requesters hold valid continuously with ids 10,11,12 (req0) and 20,21,22 (req1), all to file 0 → strobe sequence 10,20,11,21,12,22 on consecutive cycles.
- Backpressure / full: i_file_busy=3'b111 while req0 pushes 5 valid writes (FIFO_DEPTH=4) → o_req_ready[0] drops after 4 accepts and no strobes. Release busy → 4 strobes in push order, and ready returns the cycle after the first pop.
- Head-of-line per file: req0 head targets busy file 2, req1 head targets file 0 → req1 is served every cycle, req0 stalls until i_file_busy[2]=0, then its entry is emitted.
- Filtering: writes with id=0, id=64, and file=3 → none appears on o_setipnum_we, o_drop_cnt=3, ready stays high. Forcing the counter to 16'hFFFE and then 3 drops → counter reads 16'hFFFF.
- Async reset mid-stream: assert i_rst with 3 entries queued → outputs go to 0 immediately and FIFOs read empty; no stale strobe appears after release.
